rf_write_scheduler: RTL and testbench

// Schedules all writes into the register file's single write port. The pipeline

---
 rtl/rf_write_scheduler_if.sv | 41 ++++
 rtl/rf_write_scheduler.sv | 126 ++++++++++++
 tb/tb_rf_write_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_write_scheduler_if.sv
// Bundle of the write-port scheduler's request, hazard and register-file signals.
// The pipeline/requesters side uses the master modport; the scheduler uses slave.
interface rf_write_scheduler_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned QDEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              lnk_valid;
    logic [DATA_W-1:0] lnk_pc;
    logic              lnk_ready;
    logic              aux_valid;
    logic [ADDR_W-1:0] aux_dest;
    logic [DATA_W-1:0] aux_data;
    logic              aux_ready;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic              hz1;
    logic              hz2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_dest;
    logic [DATA_W-1:0] rf_data;
    logic              pipe_stall;
    logic [CNT_W-1:0]  q_count;

    modport master (
        output wb_en, wb_dest, wb_data, lnk_valid, lnk_pc, aux_valid, aux_dest, aux_data,
               src1, src2,
        input  lnk_ready, aux_ready, hz1, hz2, rf_we, rf_dest, rf_data, pipe_stall, q_count
    );

    modport slave (
        input  wb_en, wb_dest, wb_data, lnk_valid, lnk_pc, aux_valid, aux_dest, aux_data,
               src1, src2,
        output lnk_ready, aux_ready, hz1, hz2, rf_we, rf_dest, rf_data, pipe_stall, q_count
    );
endinterface

// File: rtl/rf_write_scheduler.sv
// Arbitrates the register file's single write port. Pipeline write-back always
// wins; link and auxiliary writes wait in a small circular buffer and drain into
// idle cycles. Newer write-backs cancel older buffered writes to the same register.
module rf_write_scheduler #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned LR_IDX     = 14,
    parameter int unsigned STARVE_MAX = 8
) (
    input logic                 clk,
    input logic                 rst,
    rf_write_scheduler_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX) + 1;

    logic [QDEPTH-1:0] live_q, live_d;
    logic [ADDR_W-1:0] dest_q [QDEPTH];
    logic [DATA_W-1:0] data_q [QDEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              stall_q, stall_d;

    logic              empty, not_full, head_live, drain, blocked;
    logic              lnk_fire, aux_fire, enq;
    logic [ADDR_W-1:0] enq_dest;
    logic [DATA_W-1:0] enq_data;

    assign empty     = (count_q == '0);
    assign not_full  = (count_q < CNT_W'(QDEPTH));
    assign head_live = !empty && live_q[head_q];
    // Head leaves the buffer on every idle write-port cycle; suppressed in reset so
    // a pending write is discarded rather than written.
    assign drain     = !empty && !bus.wb_en && !rst;
    assign blocked   = head_live && bus.wb_en;

    assign bus.lnk_ready  = not_full;
    assign bus.aux_ready  = not_full && !bus.lnk_valid;
    assign lnk_fire       = bus.lnk_valid && not_full;
    assign aux_fire       = bus.aux_valid && bus.aux_ready;
    assign enq            = lnk_fire || aux_fire;
    assign enq_dest       = lnk_fire ? ADDR_W'(LR_IDX) : bus.aux_dest;
    assign enq_data       = lnk_fire ? bus.lnk_pc : bus.aux_data;
    assign bus.pipe_stall = stall_q;
    assign bus.q_count    = count_q;

    // Write-port mux: write-back first, otherwise a live head entry.
    always_comb begin
        bus.rf_we   = 1'b0;
        bus.rf_dest = '0;
        bus.rf_data = '0;
        if (bus.wb_en) begin
            bus.rf_we   = 1'b1;
            bus.rf_dest = bus.wb_dest;
            bus.rf_data = bus.wb_data;
        end else if (drain && head_live) begin
            bus.rf_we   = 1'b1;
            bus.rf_dest = dest_q[head_q];
            bus.rf_data = data_q[head_q];
        end
    end

    // Read hazards against every live buffered entry, including the one draining now.
    always_comb begin
        bus.hz1 = 1'b0;
        bus.hz2 = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (live_q[i] && dest_q[i] == bus.src1) bus.hz1 = 1'b1;
            if (live_q[i] && dest_q[i] == bus.src2) bus.hz2 = 1'b1;
        end
    end

    // Live bits: cancel on matching write-back, clear on pop, set on enqueue.
    // The enqueue comes last so a same-cycle entry survives cancellation.
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < QDEPTH; i++) begin
            if (bus.wb_en && dest_q[i] == bus.wb_dest) live_d[i] = 1'b0;
        end
        if (drain) live_d[head_q] = 1'b0;
        if (enq)   live_d[tail_q] = 1'b1;
    end

    // Starvation tracking: counts consecutive blocked cycles of a live head.
    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (drain || empty) begin
            starve_d = '0;
            if (drain) stall_d = 1'b0;
        end else if (blocked) begin
            if (starve_q == STV_W'(STARVE_MAX - 1)) stall_d = 1'b1;
            else                                    starve_d = starve_q + STV_W'(1);
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            live_q   <= live_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            if (drain) head_q <= head_q + PTR_W'(1);
            if (enq)   tail_q <= tail_q + PTR_W'(1);
            count_q  <= count_q + CNT_W'(enq) - CNT_W'(drain);
        end
    end

    // Entry payload; needs no reset since live_q qualifies every use.
    always_ff @(posedge clk) begin
        if (enq) begin
            dest_q[tail_q] <= enq_dest;
            data_q[tail_q] <= enq_data;
        end
    end
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a queue-based model.
module tb_rf_write_scheduler;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned QDEPTH     = 4;
    localparam int unsigned LR_IDX     = 14;
    localparam int unsigned STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_write_scheduler_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) bus ();

    rf_write_scheduler #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .QDEPTH    (QDEPTH),
        .LR_IDX    (LR_IDX),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: pending writes in arrival order, plus blocked-run length.
    typedef struct {
        logic        live;
        logic [3:0]  dest;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];
    int   blocked_run = 0;
    bit   m_stall     = 1'b0;

    task automatic check_outputs(input string tag);
        int          cnt;
        logic        e_we;
        logic [3:0]  e_dest;
        logic [31:0] e_data;
        logic        e_hz1, e_hz2;
        cnt    = mq.size();
        e_we   = 1'b0;
        e_dest = 4'd0;
        e_data = 32'h0;
        if (bus.wb_en) begin
            e_we = 1'b1; e_dest = bus.wb_dest; e_data = bus.wb_data;
        end else if (!rst && cnt > 0 && mq[0].live) begin
            e_we = 1'b1; e_dest = mq[0].dest; e_data = mq[0].data;
        end
        e_hz1 = 1'b0;
        e_hz2 = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].live && mq[i].dest == bus.src1) e_hz1 = 1'b1;
            if (mq[i].live && mq[i].dest == bus.src2) e_hz2 = 1'b1;
        end
        chk({tag, " rf_we"},      32'(bus.rf_we),      32'(e_we));
        chk({tag, " rf_dest"},    32'(bus.rf_dest),    32'(e_dest));
        chk({tag, " rf_data"},    bus.rf_data,         e_data);
        chk({tag, " hz1"},        32'(bus.hz1),        32'(e_hz1));
        chk({tag, " hz2"},        32'(bus.hz2),        32'(e_hz2));
        chk({tag, " q_count"},    32'(bus.q_count),    32'(cnt));
        chk({tag, " lnk_ready"},  32'(bus.lnk_ready),  32'(cnt < QDEPTH));
        chk({tag, " aux_ready"},  32'(bus.aux_ready),  32'(cnt < QDEPTH && !bus.lnk_valid));
        chk({tag, " pipe_stall"}, 32'(bus.pipe_stall), 32'(m_stall));
    endtask

    task automatic model_update();
        int   cnt;
        bit   pop, blk;
        ent_t e;
        cnt = mq.size();
        if (rst) begin
            mq.delete();
            blocked_run = 0;
            m_stall     = 1'b0;
            return;
        end
        pop = (cnt > 0) && !bus.wb_en;
        blk = (cnt > 0) && mq[0].live && bus.wb_en;
        if (bus.wb_en) begin
            foreach (mq[i]) if (mq[i].dest == bus.wb_dest) mq[i].live = 1'b0;
        end
        if (pop) begin
            void'(mq.pop_front());
            blocked_run = 0;
            m_stall     = 1'b0;
        end else if (cnt == 0) begin
            blocked_run = 0;
        end else if (blk) begin
            blocked_run++;
            if (blocked_run >= STARVE_MAX) m_stall = 1'b1;
        end
        if (cnt < QDEPTH) begin
            if (bus.lnk_valid) begin
                e.live = 1'b1; e.dest = 4'(LR_IDX); e.data = bus.lnk_pc;
                mq.push_back(e);
            end else if (bus.aux_valid) begin
                e.live = 1'b1; e.dest = bus.aux_dest; e.data = bus.aux_data;
                mq.push_back(e);
            end
        end
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled on negedge.
    task automatic at_negedge(input string tag);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic finish_cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag);
        at_negedge(tag);
        finish_cycle();
    endtask

    task automatic idle();
        bus.wb_en     = 1'b0;
        bus.wb_dest   = 4'd0;
        bus.wb_data   = 32'h0;
        bus.lnk_valid = 1'b0;
        bus.lnk_pc    = 32'h0;
        bus.aux_valid = 1'b0;
        bus.aux_dest  = 4'd0;
        bus.aux_data  = 32'h0;
        bus.src1      = 4'd0;
        bus.src2      = 4'd0;
    endtask

    typedef struct {
        logic        wb_en;
        logic [3:0]  wb_dest;
        logic [31:0] wb_data;
        logic        lnk_valid;
        logic [31:0] lnk_pc;
        logic        aux_valid;
        logic [3:0]  aux_dest;
        logic [31:0] aux_data;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic        e_lr;
        logic        e_ar;
        logic        e_we;
        logic [3:0]  e_dest;
        logic [31:0] e_data;
        logic        e_hz1;
        logic        e_hz2;
        logic [2:0]  e_q;
        logic        e_stall;
    } vec_t;
    vec_t vt[8];

    initial begin
        // Link write, then link+aux collision (link wins), drained LR then R3.
        vt[0] = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0,
                  1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0};
        vt[1] = '{1'b0, 4'd0, 32'h0, 1'b1, 32'h100, 1'b0, 4'd0, 32'h0, 4'd14, 4'd0,
                  1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0};
        vt[2] = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd14, 4'd3,
                  1'b1, 1'b1, 1'b1, 4'd14, 32'h100, 1'b1, 1'b0, 3'd1, 1'b0};
        vt[3] = '{1'b0, 4'd0, 32'h0, 1'b1, 32'h200, 1'b1, 4'd3, 32'h33, 4'd0, 4'd3,
                  1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0};
        vt[4] = '{1'b1, 4'd7, 32'h77, 1'b0, 32'h0, 1'b1, 4'd3, 32'h33, 4'd14, 4'd0,
                  1'b1, 1'b1, 1'b1, 4'd7, 32'h77, 1'b1, 1'b0, 3'd1, 1'b0};
        vt[5] = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd14, 4'd3,
                  1'b1, 1'b1, 1'b1, 4'd14, 32'h200, 1'b1, 1'b1, 3'd2, 1'b0};
        vt[6] = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd3,
                  1'b1, 1'b1, 1'b1, 4'd3, 32'h33, 1'b0, 1'b1, 3'd1, 1'b0};
        vt[7] = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd0, 4'd0,
                  1'b1, 1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0};

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();

        // Directed vector table.
        for (int k = 0; k < 8; k++) begin
            bus.wb_en     = vt[k].wb_en;
            bus.wb_dest   = vt[k].wb_dest;
            bus.wb_data   = vt[k].wb_data;
            bus.lnk_valid = vt[k].lnk_valid;
            bus.lnk_pc    = vt[k].lnk_pc;
            bus.aux_valid = vt[k].aux_valid;
            bus.aux_dest  = vt[k].aux_dest;
            bus.aux_data  = vt[k].aux_data;
            bus.src1      = vt[k].src1;
            bus.src2      = vt[k].src2;
            at_negedge($sformatf("vec%0d model", k));
            chk($sformatf("vec%0d lnk_ready", k),  32'(bus.lnk_ready),  32'(vt[k].e_lr));
            chk($sformatf("vec%0d aux_ready", k),  32'(bus.aux_ready),  32'(vt[k].e_ar));
            chk($sformatf("vec%0d rf_we", k),      32'(bus.rf_we),      32'(vt[k].e_we));
            chk($sformatf("vec%0d rf_dest", k),    32'(bus.rf_dest),    32'(vt[k].e_dest));
            chk($sformatf("vec%0d rf_data", k),    bus.rf_data,         vt[k].e_data);
            chk($sformatf("vec%0d hz1", k),        32'(bus.hz1),        32'(vt[k].e_hz1));
            chk($sformatf("vec%0d hz2", k),        32'(bus.hz2),        32'(vt[k].e_hz2));
            chk($sformatf("vec%0d q_count", k),    32'(bus.q_count),    32'(vt[k].e_q));
            chk($sformatf("vec%0d pipe_stall", k), 32'(bus.pipe_stall), 32'(vt[k].e_stall));
            finish_cycle();
        end

        // Fill the buffer behind continuous write-backs, then drain.
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.wb_en     = 1'b1;
            bus.wb_dest   = 4'd0;
            bus.wb_data   = 32'(i);
            bus.aux_valid = 1'b1;
            bus.aux_dest  = 4'(8 + i);
            bus.aux_data  = 32'hA0 + 32'(i);
            step("fill");
        end
        bus.aux_valid = 1'b0;
        at_negedge("full");
        chk("full q_count",   32'(bus.q_count),   32'd4);
        chk("full lnk_ready", 32'(bus.lnk_ready), 32'd0);
        chk("full aux_ready", 32'(bus.aux_ready), 32'd0);
        finish_cycle();
        bus.wb_en = 1'b0;
        at_negedge("drain0");
        chk("drain0 rf_dest", 32'(bus.rf_dest), 32'd8);
        finish_cycle();
        at_negedge("drain1");
        chk("drain1 q_count",   32'(bus.q_count),   32'd3);
        chk("drain1 lnk_ready", 32'(bus.lnk_ready), 32'd1);
        finish_cycle();
        repeat (3) step("drain");

        // Stale pending write cancelled by a newer write-back.
        idle();
        bus.aux_valid = 1'b1; bus.aux_dest = 4'd5; bus.aux_data = 32'hAA; bus.src1 = 4'd5;
        step("cancel enq");
        bus.aux_valid = 1'b0;
        bus.wb_en = 1'b1; bus.wb_dest = 4'd5; bus.wb_data = 32'hBB;
        at_negedge("cancel wb");
        chk("cancel wb hz1",     32'(bus.hz1), 32'd1);
        chk("cancel wb rf_data", bus.rf_data,  32'hBB);
        finish_cycle();
        bus.wb_en = 1'b0;
        at_negedge("cancel dead");
        chk("cancel dead hz1",   32'(bus.hz1),     32'd0);
        chk("cancel dead rf_we", 32'(bus.rf_we),   32'd0);
        chk("cancel dead q",     32'(bus.q_count), 32'd1);
        finish_cycle();
        at_negedge("cancel empty");
        chk("cancel empty q", 32'(bus.q_count), 32'd0);
        finish_cycle();

        // Starvation: one live entry blocked for STARVE_MAX cycles.
        idle();
        bus.lnk_valid = 1'b1; bus.lnk_pc = 32'h400;
        step("starve enq");
        bus.lnk_valid = 1'b0;
        bus.wb_en = 1'b1; bus.wb_dest = 4'd1;
        for (int i = 0; i < STARVE_MAX; i++) begin
            bus.wb_data = 32'h1000 + 32'(i);
            at_negedge("starve blk");
            chk($sformatf("starve blk%0d pipe_stall", i), 32'(bus.pipe_stall), 32'd0);
            finish_cycle();
        end
        bus.wb_en = 1'b0;
        at_negedge("starve release");
        chk("starve release pipe_stall", 32'(bus.pipe_stall), 32'd1);
        chk("starve release rf_data",    bus.rf_data,         32'h400);
        finish_cycle();
        at_negedge("starve after");
        chk("starve after pipe_stall", 32'(bus.pipe_stall), 32'd0);
        finish_cycle();

        // Reset with three pending entries discards them.
        idle();
        for (int i = 0; i < 3; i++) begin
            bus.wb_en = 1'b1; bus.wb_dest = 4'd0;
            bus.aux_valid = 1'b1; bus.aux_dest = 4'(9 + i); bus.aux_data = 32'hC0 + 32'(i);
            step("rst fill");
        end
        idle();
        rst = 1'b1;
        at_negedge("rst hold");
        chk("rst hold rf_we", 32'(bus.rf_we), 32'd0);
        finish_cycle();
        rst = 1'b0;
        at_negedge("rst after");
        chk("rst after q_count",    32'(bus.q_count),    32'd0);
        chk("rst after rf_we",      32'(bus.rf_we),      32'd0);
        chk("rst after pipe_stall", 32'(bus.pipe_stall), 32'd0);
        finish_cycle();
        step("rst idle");

        // Randomized traffic in phases of increasing write-back pressure.
        for (int n = 0; n < 900; n++) begin
            int wb_pct;
            wb_pct = (n / 100) % 3 == 0 ? 20 : ((n / 100) % 3 == 1 ? 60 : 95);
            rst           = ($urandom_range(0, 149) == 0);
            bus.wb_en     = ($urandom_range(0, 99) < wb_pct);
            bus.wb_dest   = 4'($urandom_range(0, 15));
            bus.wb_data   = $urandom;
            bus.lnk_valid = ($urandom_range(0, 99) < 25);
            bus.lnk_pc    = $urandom;
            bus.aux_valid = ($urandom_range(0, 99) < 40);
            bus.aux_dest  = 4'($urandom_range(0, 15));
            bus.aux_data  = $urandom;
            bus.src1      = 4'($urandom_range(0, 15));
            bus.src2      = 4'($urandom_range(0, 15));
            step("rand");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
